// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI bus master, one DATA_W-bit frame per request; define SPI_MASTER_LOOPBACK_EN to sample mosi instead of miso
module spi_master #(
  parameter logic CPOL    = 1'b1,
  parameter logic CPHA    = 1'b1,
  parameter int   CLK_DIV = 4,
  parameter int   DATA_W  = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              tx_req,
  input  logic [DATA_W-1:0] data_tx,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_rx,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(2 * DATA_W);
  localparam logic [EDGE_W-1:0] SHIFT0_MAX = EDGE_W'(2 * DATA_W - 2);
  localparam logic [EDGE_W-1:0] SHIFT1_MIN = EDGE_W'(3);

  typedef enum logic [2:0] {IDLE, LEAD, XFER, LAG, GAP} state_t;

  state_t            state;
  state_t            state_nx;
  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [EDGE_W-1:0] edge_num;
  // MSB goes straight to mosi on load, so only the remaining bits are kept here
  logic [DATA_W-2:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              seg_end;
  logic              edge_fire;
  logic              shift_now;
  logic              sample_now;
  logic              sample_pend;
  logic              frame_end;
  logic              rx_bit;

  assign seg_end   = (div_cnt == DIV_LAST);
  assign edge_num  = edge_cnt + EDGE_W'(1);
  assign frame_end = (state == LAG) && seg_end;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic miso_unused;
  assign miso_unused = miso;
  assign rx_bit      = mosi;
`else
  assign rx_bit      = miso;
`endif

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state; edge_fire marks the sys_clk edge on which sclk toggles
  always_comb begin
    state_nx  = state;
    edge_fire = 1'b0;
    case (state)
      IDLE: begin
        if (tx_req) begin
          state_nx = LEAD;
        end
      end
      LEAD: begin
        if (seg_end) begin
          state_nx  = XFER;
          edge_fire = 1'b1;
        end
      end
      XFER: begin
        if (seg_end) begin
          if (edge_cnt == EDGE_LAST) begin
            state_nx = LAG;
          end else begin
            edge_fire = 1'b1;
          end
        end
      end
      LAG: begin
        if (seg_end) begin
          state_nx = GAP;
        end
      end
      GAP: begin
        if (seg_end) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Classify the upcoming edge: odd numbers are leading edges
  always_comb begin
    if (CPHA) begin
      shift_now  = edge_num[0] && (edge_num >= SHIFT1_MIN);
      sample_now = !edge_num[0];
    end else begin
      shift_now  = !edge_num[0] && (edge_num <= SHIFT0_MAX);
      sample_now = edge_num[0];
    end
  end

  // Half-period divider and sclk edge counter, both parked at zero in IDLE
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      if (state == IDLE || seg_end) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (state == IDLE) begin
        edge_cnt <= '0;
      end else if (edge_fire) begin
        edge_cnt <= edge_num;
      end
    end
  end

  // Shift registers; miso is captured one cycle after a sample edge, while sclk shows its new level
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tx_sr       <= '0;
      rx_sr       <= '0;
      mosi        <= 1'b0;
      sample_pend <= 1'b0;
    end else begin
      sample_pend <= edge_fire && sample_now;
      if (sample_pend) begin
        rx_sr <= {rx_sr[DATA_W-2:0], rx_bit};
      end
      if (state == IDLE && tx_req) begin
        tx_sr <= data_tx[DATA_W-2:0];
        mosi  <= data_tx[DATA_W-1];
      end else if (edge_fire && shift_now) begin
        tx_sr <= tx_sr << 1;
        mosi  <= tx_sr[DATA_W-2];
      end else if (frame_end) begin
        mosi  <= 1'b0;
      end
    end
  end

  // Pin and handshake outputs, registered from the next state
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cs      <= 1'b1;
      sclk    <= CPOL;
      busy    <= 1'b0;
      done    <= 1'b0;
      data_rx <= '0;
    end else begin
      cs   <= !(state_nx inside {LEAD, XFER, LAG});
      busy <= (state_nx != IDLE);
      done <= frame_end;
      if (frame_end) begin
        data_rx <= rx_sr;
      end
      if (edge_fire) begin
        sclk <= ~sclk;
      end else if (state_nx == IDLE) begin
        sclk <= CPOL;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master in mode 3 (div 4) and mode 0 (div 2) with slave models
`timescale 1ns/1ps
module tb_spi_master;

  localparam int DW     = 8;
  localparam int DIV_A  = 4;
  localparam int DIV_B  = 2;
  localparam int CSLO_A = DIV_A * (2 * DW + 2);
  localparam int CSLO_B = DIV_B * (2 * DW + 2);
  localparam int LAT_A  = CSLO_A + 1;
  localparam int LAT_B  = CSLO_B + 1;
`ifdef SPI_MASTER_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic       tx_req_a = 1'b0;
  logic [7:0] data_tx_a = 8'h00;
  logic       busy_a, done_a, cs_a, sclk_a, mosi_a, miso_a;
  logic [7:0] data_rx_a;
  logic       tx_req_b = 1'b0;
  logic [7:0] data_tx_b = 8'h00;
  logic       busy_b, done_b, cs_b, sclk_b, mosi_b, miso_b;
  logic [7:0] data_rx_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];

  spi_master #(.CPOL(1'b1), .CPHA(1'b1), .CLK_DIV(DIV_A), .DATA_W(DW)) u_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_req(tx_req_a), .data_tx(data_tx_a),
    .busy(busy_a), .done(done_a), .data_rx(data_rx_a), .cs(cs_a), .sclk(sclk_a),
    .mosi(mosi_a), .miso(miso_a)
  );

  spi_master #(.CPOL(1'b0), .CPHA(1'b0), .CLK_DIV(DIV_B), .DATA_W(DW)) u_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_req(tx_req_b), .data_tx(data_tx_b),
    .busy(busy_b), .done(done_b), .data_rx(data_rx_b), .cs(cs_b), .sclk(sclk_b),
    .mosi(mosi_b), .miso(miso_b)
  );

  always @(posedge sys_clk) cyc++;

  always @(negedge sys_clk) begin
    if (done_a === 1'b1) done_cnt_a++;
    if (done_b === 1'b1) done_cnt_b++;
  end

  // Mode 3 slave: drives on falling (leading) edges, captures mosi on rising (trailing) edges
  logic [7:0] sl_a_word = 8'h00;
  logic [7:0] sl_a_sr = 8'h00;
  logic [7:0] sl_a_cap = 8'h00;
  int         sl_a_rises = 0;
  logic       sl_a_prev_cs = 1'b1;
  logic       sl_a_prev_sclk = 1'b1;
  logic       sl_a_miso = 1'b0;
  logic       tie_miso_a = 1'b0;
  assign miso_a = tie_miso_a ? 1'b0 : sl_a_miso;

  always @(negedge sys_clk) begin
    if (sl_a_prev_cs && cs_a === 1'b0) begin
      sl_a_sr = sl_a_word;
      sl_a_cap = 8'h00;
      sl_a_rises = 0;
    end else if (cs_a === 1'b0 && sclk_a !== sl_a_prev_sclk) begin
      if (sclk_a === 1'b0) begin
        sl_a_miso = sl_a_sr[7];
        sl_a_sr = sl_a_sr << 1;
      end else begin
        sl_a_cap = {sl_a_cap[6:0], mosi_a};
        sl_a_rises++;
      end
    end
    sl_a_prev_cs = (cs_a !== 1'b0);
    sl_a_prev_sclk = sclk_a;
  end

  // Mode 0 slave: presents MSB at cs fall, shifts on falling edges, captures mosi on rising edges
  logic [7:0] sl_b_word = 8'h00;
  logic [7:0] sl_b_sr = 8'h00;
  logic [7:0] sl_b_cap = 8'h00;
  logic       sl_b_prev_cs = 1'b1;
  logic       sl_b_prev_sclk = 1'b0;
  logic       sl_b_miso = 1'b0;
  assign miso_b = sl_b_miso;

  always @(negedge sys_clk) begin
    if (sl_b_prev_cs && cs_b === 1'b0) begin
      sl_b_sr = sl_b_word;
      sl_b_miso = sl_b_sr[7];
      sl_b_sr = sl_b_sr << 1;
      sl_b_cap = 8'h00;
    end else if (cs_b === 1'b0 && sclk_b !== sl_b_prev_sclk) begin
      if (sclk_b === 1'b1) begin
        sl_b_cap = {sl_b_cap[6:0], mosi_b};
      end else begin
        sl_b_miso = sl_b_sr[7];
        sl_b_sr = sl_b_sr << 1;
      end
    end
    sl_b_prev_cs = (cs_b !== 1'b0);
    sl_b_prev_sclk = sclk_b;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Request on one negedge; t0 is chosen so that cyc - t0 is the cycle number after acceptance
  task automatic start_a(input logic [7:0] d, output int t0);
    @(negedge sys_clk);
    data_tx_a = d;
    tx_req_a = 1'b1;
    @(negedge sys_clk);
    tx_req_a = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic start_b(input logic [7:0] d, output int t0);
    @(negedge sys_clk);
    data_tx_b = d;
    tx_req_b = 1'b1;
    @(negedge sys_clk);
    tx_req_b = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic wait_done_a(input int budget, output bit seen);
    int n;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      if (done_a === 1'b1) seen = 1'b1;
      else begin
        @(negedge sys_clk);
        n++;
      end
    end
  endtask

  task automatic wait_done_b(input int budget, output bit seen);
    int n;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      if (done_b === 1'b1) seen = 1'b1;
      else begin
        @(negedge sys_clk);
        n++;
      end
    end
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    sys_rst = 1'b1;
    idle(3);
    obs = {cs_a, sclk_a, mosi_a, busy_a, done_a, data_rx_a};
    tests++; if (obs !== {5'b11000, 8'h00}) begin fails++; $display("FAIL reset_a: got %b, expected %b", obs, {5'b11000, 8'h00}); end
    obs = {cs_b, sclk_b, mosi_b, busy_b, done_b, data_rx_b};
    tests++; if (obs !== {5'b10000, 8'h00}) begin fails++; $display("FAIL reset_b: got %b, expected %b", obs, {5'b10000, 8'h00}); end
    sys_rst = 1'b0;
    idle(3);
    obs = {cs_a, sclk_a, mosi_a, busy_a, done_a, data_rx_a};
    tests++; if (obs !== {5'b11000, 8'h00}) begin fails++; $display("FAIL idle_a: got %b, expected %b", obs, {5'b11000, 8'h00}); end
    obs = {cs_b, sclk_b, mosi_b, busy_b, done_b, data_rx_b};
    tests++; if (obs !== {5'b10000, 8'h00}) begin fails++; $display("FAIL idle_b: got %b, expected %b", obs, {5'b10000, 8'h00}); end
  endtask

  task automatic test_mode11();
    int t0, lat, dc0;
    bit seen;
    logic [7:0] exp;
    sl_a_word = 8'h3C;
    sb_a.push_back(LB ? 8'hA5 : 8'h3C);
    dc0 = done_cnt_a;
    start_a(8'hA5, t0);
    data_tx_a = 8'h00;
    wait_done_a(LAT_A + 20, seen);
    lat = cyc - t0;
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL mode11_done_seen: got %0d, expected 1", seen); end
    tests++; if (lat !== LAT_A) begin fails++; $display("FAIL mode11_latency: got %0d, expected %0d", lat, LAT_A); end
    exp = sb_a.pop_front();
    tests++; if (data_rx_a !== exp) begin fails++; $display("FAIL mode11_data_rx: got %h, expected %h", data_rx_a, exp); end
    idle(DIV_A + 4);
    tests++; if ((done_cnt_a - dc0) !== 1) begin fails++; $display("FAIL mode11_done_count: got %0d, expected 1", done_cnt_a - dc0); end
    tests++; if (sl_a_cap !== 8'hA5) begin fails++; $display("FAIL mode11_mosi_bits: got %h, expected a5", sl_a_cap); end
    tests++; if (sl_a_rises !== 8) begin fails++; $display("FAIL mode11_rise_count: got %0d, expected 8", sl_a_rises); end
    tests++; if (sclk_a !== 1'b1) begin fails++; $display("FAIL mode11_sclk_idle: got %b, expected 1", sclk_a); end
  endtask

  task automatic test_mode00();
    int t0, lat, n, cs_low;
    bit seen;
    logic [7:0] exp;
    tests++; if (sclk_b !== 1'b0) begin fails++; $display("FAIL mode00_sclk_idle_pre: got %b, expected 0", sclk_b); end
    sl_b_word = 8'hF0;
    sb_b.push_back(LB ? 8'h81 : 8'hF0);
    start_b(8'h81, t0);
    cs_low = 0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < LAT_B + 20) begin
      if (done_b === 1'b1) seen = 1'b1;
      else begin
        if (cs_b === 1'b0) cs_low++;
        @(negedge sys_clk);
        n++;
      end
    end
    lat = cyc - t0;
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL mode00_done_seen: got %0d, expected 1", seen); end
    tests++; if (lat !== LAT_B) begin fails++; $display("FAIL mode00_latency: got %0d, expected %0d", lat, LAT_B); end
    tests++; if (cs_low !== CSLO_B) begin fails++; $display("FAIL mode00_cs_low: got %0d, expected %0d", cs_low, CSLO_B); end
    exp = sb_b.pop_front();
    tests++; if (data_rx_b !== exp) begin fails++; $display("FAIL mode00_data_rx: got %h, expected %h", data_rx_b, exp); end
    tests++; if (sl_b_cap !== 8'h81) begin fails++; $display("FAIL mode00_mosi_bits: got %h, expected 81", sl_b_cap); end
    idle(DIV_B + 3);
    tests++; if ({cs_b, sclk_b, busy_b} !== 3'b100) begin fails++; $display("FAIL mode00_idle_pins: got %b, expected 100", {cs_b, sclk_b, busy_b}); end
  endtask

  task automatic test_busy_ignore();
    int t0, dc0, cs_low;
    bit seen;
    logic [7:0] exp;
    sl_b_word = 8'h5C;
    sb_b.push_back(LB ? 8'h42 : 8'h5C);
    dc0 = done_cnt_b;
    start_b(8'h42, t0);
    idle(8);
    data_tx_b = 8'hFF;
    tx_req_b = 1'b1;
    idle(3);
    tx_req_b = 1'b0;
    wait_done_b(LAT_B + 20, seen);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL busy_done_seen: got %0d, expected 1", seen); end
    exp = sb_b.pop_front();
    tests++; if (data_rx_b !== exp) begin fails++; $display("FAIL busy_data_rx: got %h, expected %h", data_rx_b, exp); end
    tests++; if (sl_b_cap !== 8'h42) begin fails++; $display("FAIL busy_mosi_bits: got %h, expected 42", sl_b_cap); end
    cs_low = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (cs_b !== 1'b1) cs_low++;
    end
    tests++; if (cs_low !== 0) begin fails++; $display("FAIL busy_no_second_frame: got %0d cs-low cycles, expected 0", cs_low); end
    tests++; if ((done_cnt_b - dc0) !== 1) begin fails++; $display("FAIL busy_done_count: got %0d, expected 1", done_cnt_b - dc0); end
  endtask

  task automatic test_back_to_back();
    int frames, dones, gap_hi, gap_busy, n;
    logic prev_cs;
    logic [7:0] exp, exp_cap;
    sl_b_word = 8'h66;
    sb_b.push_back(LB ? 8'h11 : 8'h66);
    sb_b.push_back(LB ? 8'h22 : 8'h99);
    frames = 0; dones = 0; gap_hi = 0; gap_busy = 0; n = 0;
    @(negedge sys_clk);
    prev_cs = cs_b;
    data_tx_b = 8'h11;
    tx_req_b = 1'b1;
    while (dones < 2 && n < 250) begin
      @(negedge sys_clk);
      n++;
      if (done_b === 1'b1) begin
        dones++;
        exp = sb_b.pop_front();
        exp_cap = (dones == 1) ? 8'h11 : 8'h22;
        tests++; if (data_rx_b !== exp) begin fails++; $display("FAIL b2b_data_rx_%0d: got %h, expected %h", dones, data_rx_b, exp); end
        tests++; if (sl_b_cap !== exp_cap) begin fails++; $display("FAIL b2b_mosi_bits_%0d: got %h, expected %h", dones, sl_b_cap, exp_cap); end
        if (dones == 1) sl_b_word = 8'h99;
      end
      if (prev_cs === 1'b1 && cs_b === 1'b0) begin
        frames++;
        if (frames == 1) data_tx_b = 8'h22;
        else tx_req_b = 1'b0;
      end
      if (frames == 1 && dones == 1 && cs_b === 1'b1) begin
        gap_hi++;
        if (busy_b === 1'b1) gap_busy++;
      end
      prev_cs = cs_b;
    end
    tx_req_b = 1'b0;
    tests++; if (dones !== 2) begin fails++; $display("FAIL b2b_done_pulses: got %0d, expected 2", dones); end
    tests++; if (frames !== 2) begin fails++; $display("FAIL b2b_frames: got %0d, expected 2", frames); end
    // cs stays high for the GAP (busy still set) plus the single IDLE cycle in which the next request is accepted
    tests++; if (gap_busy !== DIV_B) begin fails++; $display("FAIL b2b_gap_len: got %0d, expected %0d", gap_busy, DIV_B); end
    tests++; if (gap_hi !== DIV_B + 1) begin fails++; $display("FAIL b2b_cs_high: got %0d, expected %0d", gap_hi, DIV_B + 1); end
    idle(DIV_B + 4);
  endtask

  task automatic test_reset_mid();
    int t0, dc0, edges, n, lat;
    bit seen;
    logic prev_sclk;
    logic [11:0] obs;
    logic [7:0] exp;
    sl_b_word = 8'hC3;
    dc0 = done_cnt_b;
    start_b(8'h77, t0);
    edges = 0; n = 0;
    prev_sclk = sclk_b;
    while (edges < 3 && n < 100) begin
      @(negedge sys_clk);
      n++;
      if (sclk_b !== prev_sclk) edges++;
      prev_sclk = sclk_b;
    end
    tests++; if (edges !== 3) begin fails++; $display("FAIL rstmid_edges: got %0d, expected 3", edges); end
    #2;
    sys_rst = 1'b1;
    #1;
    obs = {cs_b, sclk_b, busy_b, done_b, data_rx_b};
    tests++; if (obs !== {4'b1000, 8'h00}) begin fails++; $display("FAIL rstmid_outputs: got %b, expected %b", obs, {4'b1000, 8'h00}); end
    idle(3);
    sys_rst = 1'b0;
    idle(50);
    tests++; if (done_cnt_b !== dc0) begin fails++; $display("FAIL rstmid_no_done: got %0d, expected %0d", done_cnt_b, dc0); end
    sl_b_word = 8'hA5;
    sb_b.push_back(LB ? 8'h3C : 8'hA5);
    start_b(8'h3C, t0);
    wait_done_b(LAT_B + 20, seen);
    lat = cyc - t0;
    tests++; if (lat !== LAT_B) begin fails++; $display("FAIL rstmid_new_latency: got %0d, expected %0d", lat, LAT_B); end
    exp = sb_b.pop_front();
    tests++; if (data_rx_b !== exp) begin fails++; $display("FAIL rstmid_new_data_rx: got %h, expected %h", data_rx_b, exp); end
    idle(DIV_B + 4);
  endtask

  task automatic test_miso_tied0();
    int t0;
    bit seen;
    logic [7:0] exp;
    tie_miso_a = 1'b1;
    sb_a.push_back(LB ? 8'h5A : 8'h00);
    start_a(8'h5A, t0);
    wait_done_a(LAT_A + 20, seen);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL tied0_done_seen: got %0d, expected 1", seen); end
    exp = sb_a.pop_front();
    tests++; if (data_rx_a !== exp) begin fails++; $display("FAIL tied0_data_rx: got %h, expected %h", data_rx_a, exp); end
    tests++; if (sl_a_cap !== 8'h5A) begin fails++; $display("FAIL tied0_mosi_bits: got %h, expected 5a", sl_a_cap); end
    idle(DIV_A + 4);
    tie_miso_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode11();
    test_mode00();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_miso_tied0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
